// File: rtl/prvp_spi_pkg.sv
// Shared types and constants for the PRVP SPI master receive path.
package prvp_spi_pkg;

  localparam int SPI_WORD_W = 32;
  localparam int SPI_CNT_W  = 16;

  localparam logic [4:0] SPI_SGL_WEND  = 5'h1F;
  localparam logic [2:0] SPI_QUAD_WEND = 3'h7;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    WAIT_SPACE
  } rx_state_t;

endpackage

// File: rtl/prvp_spi_rx_outbuf.sv
// Output word register toward the RX FIFO, with an optional one-entry skid behind it
// when PRVP_SPI_RX_SKID_EN is defined. in_rdy_o says a pushed word is taken this cycle.
module prvp_spi_rx_outbuf
  import prvp_spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_vld_i,
  input  logic [SPI_WORD_W-1:0] in_dat_i,
  output logic                  in_rdy_o,
  output logic [SPI_WORD_W-1:0] out_dat_o,
  output logic                  out_vld_o,
  input  logic                  out_rdy_i
);

  logic [SPI_WORD_W-1:0] dat_q;
  logic                  vld_q;

  assign out_dat_o = dat_q;
  assign out_vld_o = vld_q;

`ifdef PRVP_SPI_RX_SKID_EN
  logic [SPI_WORD_W-1:0] skid_q;
  logic                  skid_vld_q;

  // A full skid can still take a word when data is leaving this cycle.
  assign in_rdy_o = !skid_vld_q || out_rdy_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dat_q      <= '0;
      vld_q      <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else if (!vld_q) begin
      if (in_vld_i) begin
        dat_q <= in_dat_i;
        vld_q <= 1'b1;
      end
    end else if (out_rdy_i) begin
      if (skid_vld_q) begin
        dat_q      <= skid_q;
        skid_vld_q <= in_vld_i;
        if (in_vld_i) skid_q <= in_dat_i;
      end else begin
        vld_q <= in_vld_i;
        if (in_vld_i) dat_q <= in_dat_i;
      end
    end else if (in_vld_i && !skid_vld_q) begin
      skid_q     <= in_dat_i;
      skid_vld_q <= 1'b1;
    end
  end
`else
  assign in_rdy_o = !vld_q || out_rdy_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dat_q <= '0;
      vld_q <= 1'b0;
    end else if (in_vld_i && in_rdy_o) begin
      dat_q <= in_dat_i;
      vld_q <= 1'b1;
    end else if (out_rdy_i) begin
      vld_q <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/prvp_spi_master_rx.sv
// SPI master receive shifter: samples sdi lanes on rx_edge, emits 32-bit words with 1 clk latency,
// stops the SPI clock while a completed word cannot be stored (skid via PRVP_SPI_RX_SKID_EN).
module prvp_spi_master_rx
  import prvp_spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  rx_edge,
  output logic                  rx_done,
  input  logic                  sdi0,
  input  logic                  sdi1,
  input  logic                  sdi2,
  input  logic                  sdi3,
  input  logic                  en_quad_in,
  input  logic [SPI_CNT_W-1:0]  counter_in,
  input  logic                  counter_in_upd,
  output logic [SPI_WORD_W-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  clk_en_o
);

  rx_state_t             state_q, state_d;
  logic [SPI_CNT_W-1:0]  counter_q, counter_d;
  logic [SPI_CNT_W-1:0]  counter_trgt_q;
  logic [SPI_WORD_W-1:0] data_int_q, data_int_d;
  logic                  pending_last_q, pending_last_d;

  logic                  shift_en, word_end, last;
  logic [SPI_WORD_W-1:0] shifted;
  logic                  push_vld, push_rdy;
  logic [SPI_WORD_W-1:0] push_dat;

  assign shift_en = (state_q == RECEIVE) && rx_edge;
  assign shifted  = en_quad_in ? {data_int_q[SPI_WORD_W-5:0], sdi3, sdi2, sdi1, sdi0}
                               : {data_int_q[SPI_WORD_W-2:0], sdi1};
  assign word_end = en_quad_in ? (counter_q[2:0] == SPI_QUAD_WEND)
                               : (counter_q[4:0] == SPI_SGL_WEND);
  // counter_trgt of 0 wraps to a 65536-edge transfer.
  assign last     = shift_en && (counter_q == counter_trgt_q - 16'd1);
  assign rx_done  = last;
  assign clk_en_o = (state_q == RECEIVE);

  assign push_vld = (shift_en && (word_end || last)) || (state_q == WAIT_SPACE);
  assign push_dat = (state_q == WAIT_SPACE) ? data_int_q : shifted;

  always_comb begin
    state_d        = state_q;
    counter_d      = counter_q;
    data_int_d     = data_int_q;
    pending_last_d = pending_last_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = RECEIVE;
          counter_d = '0;
        end
      end
      RECEIVE: begin
        if (shift_en) begin
          counter_d = last ? '0 : counter_q + 16'd1;
          if (word_end || last) begin
            if (push_rdy) begin
              data_int_d = '0;
              if (last) state_d = IDLE;
            end else begin
              data_int_d     = shifted;
              pending_last_d = last;
              state_d        = WAIT_SPACE;
            end
          end else begin
            data_int_d = shifted;
          end
        end
      end
      WAIT_SPACE: begin
        if (push_rdy) begin
          data_int_d = '0;
          state_d    = pending_last_q ? IDLE : RECEIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      counter_q      <= '0;
      data_int_q     <= '0;
      pending_last_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      data_int_q     <= data_int_d;
      pending_last_q <= pending_last_d;
    end
  end

  // Quad mode counts edges, four bits each.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      counter_trgt_q <= 16'h8;
    end else if (counter_in_upd) begin
      counter_trgt_q <= en_quad_in ? {2'b00, counter_in[15:2]} : counter_in;
    end
  end

  prvp_spi_rx_outbuf u_outbuf (
    .clk       (clk),
    .rstn      (rstn),
    .in_vld_i  (push_vld),
    .in_dat_i  (push_dat),
    .in_rdy_o  (push_rdy),
    .out_dat_o (data),
    .out_vld_o (data_valid),
    .out_rdy_i (data_ready)
  );

endmodule

// File: tb/tb_prvp_spi_master_rx.sv
// Scoreboard bench for prvp_spi_master_rx; expected words come from a bit-stream model.
// Build with PRVP_SPI_RX_SKID_EN defined to exercise the skid variant.
module tb_prvp_spi_master_rx;

  logic        clk = 1'b0;
  logic        rstn, en, rx_edge, rx_done;
  logic        sdi0, sdi1, sdi2, sdi3;
  logic        en_quad_in, counter_in_upd;
  logic [15:0] counter_in;
  logic [31:0] data;
  logic        data_valid, data_ready, clk_en_o;

  always #5 clk = ~clk;

  prvp_spi_master_rx dut (
    .clk            (clk),
    .rstn           (rstn),
    .en             (en),
    .rx_edge        (rx_edge),
    .rx_done        (rx_done),
    .sdi0           (sdi0),
    .sdi1           (sdi1),
    .sdi2           (sdi2),
    .sdi3           (sdi3),
    .en_quad_in     (en_quad_in),
    .counter_in     (counter_in),
    .counter_in_upd (counter_in_upd),
    .data           (data),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .clk_en_o       (clk_en_o)
  );

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          rdy_mode = 0;
  int          model_trgt;
  logic [31:0] sb[$];
  logic [3:0]  lanes[$];
  logic        mon_pv, mon_pr;
  logic [31:0] mon_pd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected words: edges grouped per 32-bit word, last word right-aligned.
  task automatic push_model(input logic quad);
    logic [31:0] w;
    int c, wpe;
    w = 0; c = 0; wpe = quad ? 8 : 32;
    foreach (lanes[i]) begin
      if (quad) w = (w << 4) | 32'(lanes[i]);
      else      w = (w << 1) | 32'(lanes[i][1]);
      c++;
      if (c == wpe || i == lanes.size() - 1) begin
        sb.push_back(w);
        w = 0; c = 0;
      end
    end
  endtask

  task automatic fill_random(input int n);
    lanes.delete();
    repeat (n) lanes.push_back(4'($urandom));
  endtask

  task automatic set_target(input logic quad, input int cnt);
    en_quad_in     = quad;
    counter_in     = 16'(cnt);
    counter_in_upd = 1'b1;
    @(posedge clk); #1;
    counter_in_upd = 1'b0;
    model_trgt     = quad ? (cnt >> 2) : cnt;
  endtask

  task automatic garbage_cycle();
    rx_edge = 1'($urandom_range(0, 1));
    {sdi3, sdi2, sdi1, sdi0} = 4'($urandom);
    @(posedge clk); #1;
    rx_edge = 1'b0;
  endtask

  // Acts as the clock generator: no real edge while clk_en_o is low.
  task automatic drive_edge(input logic [3:0] ln, input logic exp_last, input int gap);
    int guard;
    guard = 0;
    while (!clk_en_o && guard < 5000) begin
      garbage_cycle();
      guard++;
    end
    if (guard >= 5000) begin
      chk_cnt++;
      $display("FAIL edge_wait: clk_en_o=0 expected 1");
    end
    rx_edge = 1'b1;
    {sdi3, sdi2, sdi1, sdi0} = ln;
    @(negedge clk);
    check("rx_done", 32'(rx_done), 32'(exp_last));
    @(posedge clk); #1;
    rx_edge = 1'b0;
    {sdi3, sdi2, sdi1, sdi0} = 4'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic start_xfer();
    repeat (2) garbage_cycle();
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 5000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 5000) begin
      chk_cnt++;
      $display("FAIL drain: %0d words outstanding expected 0", sb.size());
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic run_xfer(input logic quad, input int gap_max);
    push_model(quad);
    start_xfer();
    foreach (lanes[i])
      drive_edge(lanes[i], i == lanes.size() - 1, $urandom_range(0, gap_max));
    wait_idle();
  endtask

  initial begin
    data_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       data_ready = 1'b1;
        1:       data_ready = 1'($urandom_range(0, 1));
        default: data_ready = 1'b0;
      endcase
    end
  end

  initial begin
    logic [31:0] exp_w;
    mon_pv = 1'b0; mon_pr = 1'b0; mon_pd = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        mon_pv = 1'b0; mon_pr = 1'b0;
      end else begin
        if (mon_pv && !mon_pr) begin
          check("hold_valid", 32'(data_valid), 32'd1);
          check("hold_data", data, mon_pd);
        end
        if (data_valid && data_ready) begin
          if (sb.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_word: got %h expected none", data);
          end else begin
            exp_w = sb.pop_front();
            check("word", data, exp_w);
          end
        end
        mon_pv = data_valid; mon_pr = data_ready; mon_pd = data;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  ln;
    logic        quad;
    int          cnt;

    rstn = 1'b0; en = 1'b0; rx_edge = 1'b0; en_quad_in = 1'b0;
    counter_in = '0; counter_in_upd = 1'b0;
    {sdi3, sdi2, sdi1, sdi0} = 4'h0;
    model_trgt = 8;
    #12;
    check("rst_data", data, 32'h0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_done", 32'(rx_done), 32'd0);
    check("rst_clk_en", 32'(clk_en_o), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single 32-bit word, latency and return to idle
    set_target(1'b0, 32);
    d = 32'hA5C3_0F96;
    lanes.delete();
    for (int i = 31; i >= 0; i--) begin
      ln = 4'($urandom);
      ln[1] = d[i];
      lanes.push_back(ln);
    end
    push_model(1'b0);
    start_xfer();
    for (int i = 0; i < 32; i++)
      drive_edge(lanes[i], i == 31, (i == 31) ? 0 : $urandom_range(0, 2));
    @(negedge clk);
    check("lat_valid", 32'(data_valid), 32'd1);
    check("idle_clk_en", 32'(clk_en_o), 32'd0);
    @(posedge clk); #1;
    wait_idle();

    // Quad, two words from counting nibbles
    set_target(1'b1, 64);
    lanes.delete();
    for (int i = 1; i <= 16; i++) lanes.push_back(4'(i));
    run_xfer(1'b1, 2);

    // Partial single-mode word
    set_target(1'b0, 12);
    d = 32'hABC;
    lanes.delete();
    for (int i = 11; i >= 0; i--) begin
      ln = 4'($urandom);
      ln[1] = d[i];
      lanes.push_back(ln);
    end
    run_xfer(1'b0, 1);

    // Backpressure gating on a three-word transfer
    set_target(1'b0, 96);
    fill_random(96);
    push_model(1'b0);
    rdy_mode = 2;
    start_xfer();
    for (int i = 0; i < 64; i++)
      drive_edge(lanes[i], 1'b0, (i == 63) ? 0 : $urandom_range(0, 1));
`ifdef PRVP_SPI_RX_SKID_EN
    check("skid_no_gate", 32'(clk_en_o), 32'd1);
    for (int i = 64; i < 96; i++)
      drive_edge(lanes[i], i == 95, (i == 95) ? 0 : $urandom_range(0, 1));
    check("gate_after_w3", 32'(clk_en_o), 32'd0);
`else
    check("gate_after_w2", 32'(clk_en_o), 32'd0);
`endif
    repeat (20) garbage_cycle();
    check("gate_hold", 32'(clk_en_o), 32'd0);
    check("stall_valid", 32'(data_valid), 32'd1);
    rdy_mode = 0;
`ifndef PRVP_SPI_RX_SKID_EN
    for (int i = 64; i < 96; i++)
      drive_edge(lanes[i], i == 95, $urandom_range(0, 1));
`endif
    wait_idle();

    // Reset in the middle of a transfer drops the partial word
    set_target(1'b0, 32);
    fill_random(32);
    start_xfer();
    for (int i = 0; i < 16; i++) drive_edge(lanes[i], 1'b0, 0);
    rx_edge = 1'b1;
    {sdi3, sdi2, sdi1, sdi0} = lanes[16];
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_data", data, 32'h0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    check("midrst_done", 32'(rx_done), 32'd0);
    check("midrst_clk_en", 32'(clk_en_o), 32'd0);
    @(posedge clk); #1;
    rx_edge = 1'b0;
    rstn = 1'b1;
    model_trgt = 8;
    fill_random(model_trgt);
    run_xfer(1'b0, 1);

    // Quad target from counter_in=40: one full word plus an 8-bit tail
    set_target(1'b1, 40);
    check("quad_trgt", 32'(model_trgt), 32'd10);
    fill_random(model_trgt);
    run_xfer(1'b1, 1);

    // Random transfers under random backpressure
    rdy_mode = 1;
    for (int t = 0; t < 12; t++) begin
      quad = 1'($urandom_range(0, 1));
      cnt  = quad ? $urandom_range(4, 100) : $urandom_range(1, 80);
      set_target(quad, cnt);
      fill_random(model_trgt);
      run_xfer(quad, 2);
    end
    rdy_mode = 0;
    repeat (4) begin @(posedge clk); #1; end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
